// File: rtl/ifetch.sv
// Instruction fetch unit: walks a PC, issues one word read at a time and
// pushes the returned instruction into the instruction queue.
// Optional build macro ICACHE_EN adds a 16-entry direct-mapped instruction cache.
module ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        full,
  output logic        inst_rdy,
  output logic [31:0] inst,
  output logic [31:0] pc_out,
  input  logic        jump,
  input  logic [31:0] jump_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_done,
  input  logic [31:0] mem_data
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned IDX_W = 4;
  localparam int unsigned LINES = 16;
  localparam int unsigned TAG_W = 26;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t          state, state_d;
  logic [XLEN-1:0] pc, pc_d;
  logic            drop, drop_d;
  logic            inst_rdy_d;
  logic [XLEN-1:0] inst_d;
  logic [XLEN-1:0] pc_out_d;
  logic            mem_req_d;
  logic [XLEN-1:0] mem_addr_d;

  logic            hit_c;
  logic [XLEN-1:0] hit_word_c;

`ifdef ICACHE_EN
  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [XLEN-1:0]  data_mem [LINES];
  logic [IDX_W-1:0] rd_idx_c;
  logic [IDX_W-1:0] wr_idx_c;
  logic             fill_c;

  // Lookup uses the current PC; fills use the address of the outstanding read.
  assign rd_idx_c   = pc[5:2];
  assign wr_idx_c   = mem_addr[5:2];
  assign fill_c     = rdy && (state == S_WAIT) && mem_done;
  assign hit_c      = valid[rd_idx_c] && (tag_mem[rd_idx_c] == pc[31:6]);
  assign hit_word_c = data_mem[rd_idx_c];

  // Valid bits: cleared by reset, set on every completed read (dropped ones too).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
    end else if (fill_c) begin
      valid[wr_idx_c] <= 1'b1;
    end
  end

  // Tag and data storage; no reset needed since valid bits gate every use.
  always_ff @(posedge clk) begin
    if (fill_c) begin
      tag_mem[wr_idx_c]  <= mem_addr[31:6];
      data_mem[wr_idx_c] <= mem_data;
    end
  end
`else
  assign hit_c      = 1'b0;
  assign hit_word_c = '0;
`endif

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      drop     <= 1'b0;
      inst_rdy <= 1'b0;
      inst     <= '0;
      pc_out   <= '0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
    end else begin
      state    <= state_d;
      pc       <= pc_d;
      drop     <= drop_d;
      inst_rdy <= inst_rdy_d;
      inst     <= inst_d;
      pc_out   <= pc_out_d;
      mem_req  <= mem_req_d;
      mem_addr <= mem_addr_d;
    end
  end

  // Next-state logic; everything holds while rdy is low except the inst_rdy pulse.
  always_comb begin
    state_d    = state;
    pc_d       = pc;
    drop_d     = drop;
    inst_rdy_d = 1'b0;
    inst_d     = inst;
    pc_out_d   = pc_out;
    mem_req_d  = mem_req;
    mem_addr_d = mem_addr;

    if (rdy) begin
      case (state)
        S_IDLE: begin
          if (jump) begin
            pc_d = jump_pc;
          end else if (!full) begin
            if (hit_c) begin
              inst_d     = hit_word_c;
              pc_out_d   = pc;
              inst_rdy_d = 1'b1;
              pc_d       = pc + XLEN'(4);
            end else begin
              mem_req_d  = 1'b1;
              mem_addr_d = pc;
              state_d    = S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (mem_done) begin
            mem_req_d = 1'b0;
            drop_d    = 1'b0;
            state_d   = S_IDLE;
            if (jump) begin
              pc_d = jump_pc;
            end else if (!drop) begin
              inst_d     = mem_data;
              pc_out_d   = pc;
              inst_rdy_d = 1'b1;
              pc_d       = pc + XLEN'(4);
            end
          end else if (jump) begin
            // Memory cannot abort: remember to discard the pending word.
            pc_d   = jump_pc;
            drop_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: a fixed-latency memory responder, a
// scoreboard of expected request addresses and delivered instructions, a
// jump-target vector table and directed multi-cycle sequences.
module tb_ifetch;

  logic        clk = 1'b0;
  logic        rst, rdy, full, jump, mem_done;
  logic [31:0] jump_pc, mem_data;
  logic        inst_rdy, mem_req;
  logic [31:0] inst, pc_out, mem_addr;

  always #5 clk = ~clk;

  ifetch #(.RESET_PC(32'h0)) dut (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .full     (full),
    .inst_rdy (inst_rdy),
    .inst     (inst),
    .pc_out   (pc_out),
    .jump     (jump),
    .jump_pc  (jump_pc),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_done (mem_done),
    .mem_data (mem_data)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic [31:0] target;
    logic [31:0] next_addr;
  } vec_t;

  exp_t        exp_q[$];
  logic [31:0] addr_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          mem_cnt = 0;
  logic        req_q = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h0000_0013;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Memory: answers two rdy-cycles after it first sees a request.
  initial begin
    mem_done = 1'b0;
    mem_data = '0;
    forever begin
      @(negedge clk or negedge rst);
      if (!rst) begin
        mem_done = 1'b0;
        mem_cnt  = 0;
      end else if (mem_done) begin
        mem_done = 1'b0;
      end else if (mem_req && rdy) begin
        mem_cnt++;
        if (mem_cnt == 2) begin
          mem_done = 1'b1;
          mem_data = mem_word(mem_addr);
          mem_cnt  = 0;
        end
      end
    end
  end

  // Scoreboard: each request rise and each inst_rdy pulse pops an expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        if (mem_req && !req_q) begin
          if (addr_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_req: addr %h, expected no request", mem_addr);
          end else begin
            check("mem_addr", mem_addr, addr_q.pop_front());
          end
        end
        if (inst_rdy) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_inst_rdy: pc_out %h, expected no pulse", pc_out);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("pc_out", pc_out, e.pc);
            check("inst", inst, e.data);
          end
        end
      end
      req_q = mem_req;
    end
  end

  task automatic push_fetch(input logic [31:0] a);
    exp_t e;
    e.pc   = a;
    e.data = mem_word(a);
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    addr_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_req(input logic [31:0] a);
    bit found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mem_req && mem_addr == a) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_req: no request seen, expected addr %h", a);
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && addr_q.size() == 0 && !mem_req) break;
    end
    repeat (3) @(negedge clk);
    check("pending_inst", 32'(exp_q.size()), 32'd0);
    check("pending_req", 32'(addr_q.size()), 32'd0);
  endtask

  task automatic jump_idle(input logic [31:0] target);
    @(negedge clk);
    jump    = 1'b1;
    jump_pc = target;
    @(negedge clk);
    jump    = 1'b0;
  endtask

  vec_t vecs[4];

  initial begin
    vecs[0] = '{target: 32'h0000_0200, next_addr: 32'h0000_0204};
    vecs[1] = '{target: 32'hFFFF_FFFC, next_addr: 32'h0000_0000};
    vecs[2] = '{target: 32'h0000_1000, next_addr: 32'h0000_1004};
    vecs[3] = '{target: 32'h8000_0040, next_addr: 32'h8000_0044};

    rst = 1'b1; rdy = 1'b1; full = 1'b1; jump = 1'b0; jump_pc = '0;
    #2 rst = 1'b0;
    #1;
    check("rst_inst_rdy", 32'(inst_rdy), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_pc_out", pc_out, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Queue full after reset: no request until released.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("full_no_req", 32'(mem_req), 32'd0);
    end

    // Sequential fetch 0,4,8; full rises during the last fetch, which still delivers.
    for (int a = 0; a <= 8; a += 4) begin
      addr_q.push_back(32'(a));
      push_fetch(32'(a));
    end
    full = 1'b0;
    wait_req(32'h8);
    full = 1'b1;
    wait_drain();

    // Jump while waiting on addr 8: that word is dropped.
    do_reset();
    addr_q.push_back(32'h0); addr_q.push_back(32'h4);
    addr_q.push_back(32'h8); addr_q.push_back(32'h100);
    push_fetch(32'h0); push_fetch(32'h4); push_fetch(32'h100);
    full = 1'b0;
    wait_req(32'h8);
    jump = 1'b1; jump_pc = 32'h100;
    @(negedge clk);
    jump = 1'b0;
    wait_req(32'h100);
    full = 1'b1;
    wait_drain();

    // Jump on the same edge as mem_done: data discarded, redirect taken.
    addr_q.push_back(32'h104); addr_q.push_back(32'h300);
    push_fetch(32'h300);
    full = 1'b0;
    wait_req(32'h104);
    @(negedge clk);
    jump = 1'b1; jump_pc = 32'h300;
    @(negedge clk);
    jump = 1'b0;
    wait_req(32'h300);
    full = 1'b1;
    wait_drain();

    // rdy low for three cycles mid-fetch; a jump during the freeze is ignored.
    addr_q.push_back(32'h304);
    push_fetch(32'h304);
    full = 1'b0;
    wait_req(32'h304);
    rdy  = 1'b0;
    full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("frz_mem_req", 32'(mem_req), 32'd1);
      check("frz_mem_addr", mem_addr, 32'h304);
      check("frz_inst_rdy", 32'(inst_rdy), 32'd0);
      jump = (i == 1); jump_pc = 32'h500;
    end
    jump = 1'b0;
    rdy  = 1'b1;
    wait_drain();
    addr_q.push_back(32'h308);
    push_fetch(32'h308);
    full = 1'b0;
    wait_req(32'h308);
    full = 1'b1;
    wait_drain();

    // Jump-target table, including PC wrap past 2^32.
    do_reset();
    for (int v = 0; v < 4; v++) begin
      jump_idle(vecs[v].target);
      addr_q.push_back(vecs[v].target);
      addr_q.push_back(vecs[v].next_addr);
      push_fetch(vecs[v].target);
      push_fetch(vecs[v].next_addr);
      full = 1'b0;
      wait_req(vecs[v].next_addr);
      full = 1'b1;
      wait_drain();
    end

    // Reset in the middle of a fetch abandons it and restarts at RESET_PC.
    addr_q.push_back(32'h8000_0048);
    full = 1'b0;
    wait_req(32'h8000_0048);
    full = 1'b1;
    rst  = 1'b0;
    exp_q.delete();
    addr_q.delete();
    #1;
    check("midrst_mem_req", 32'(mem_req), 32'd0);
    check("midrst_mem_addr", mem_addr, 32'd0);
    check("midrst_pc_out", pc_out, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    addr_q.push_back(32'h0);
    push_fetch(32'h0);
    full = 1'b0;
    wait_req(32'h0);
    full = 1'b1;
    wait_drain();

`ifdef ICACHE_EN
    // Loop back to 0x10: later passes hit the cache for already-fetched words.
    do_reset();
    jump_idle(32'h10);
    for (int a = 'h10; a <= 'h18; a += 4) begin
      addr_q.push_back(32'(a));
      push_fetch(32'(a));
    end
    full = 1'b0;
    wait_req(32'h18);
    full = 1'b1;
    wait_drain();
    for (int p = 0; p < 2; p++) begin
      logic [31:0] stop;
      stop = 32'h1C + 32'(4 * p);
      jump_idle(32'h10);
      for (logic [31:0] a = 32'h10; a <= stop; a += 32'd4) push_fetch(a);
      addr_q.push_back(stop);
      full = 1'b0;
      @(negedge clk);
      check("hit_inst_rdy", 32'(inst_rdy), 32'd1);
      check("hit_pc_out", pc_out, 32'h10);
      check("hit_no_req", 32'(mem_req), 32'd0);
      wait_req(stop);
      full = 1'b1;
      wait_drain();
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
